// File: rtl/fft_sched.sv
// fft_sched: shares one FFT datapath between display (0) and host (1).
// Arbitrates per frame, drives the FFT request level, tags output beats
// with bin/last markers and tracks the per-frame peak magnitude.
module fft_sched #(
  parameter int unsigned RN      = 16,
  parameter int unsigned SIZE    = 1024,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned GAP     = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [1:0]              req,
  output logic [1:0]              gnt,
  output logic [1:0]              done,
  output logic                    err,
  output logic                    fft_request,
  input  logic                    fft_valid,
  input  logic [RN-1:0]           fft_data,
  output logic                    out_valid,
  output logic [RN-1:0]           out_data,
  output logic [$clog2(SIZE)-1:0] out_bin,
  output logic                    out_last,
  output logic [RN-1:0]           peak_mag,
  output logic [$clog2(SIZE)-1:0] peak_bin
);

  localparam int unsigned BW = $clog2(SIZE);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned GW = $clog2(GAP) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            last_gnt_q, last_gnt_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            abort_q, abort_d;
  logic            out_valid_q, out_valid_d;
  logic [RN-1:0]   out_data_q, out_data_d;
  logic [BW-1:0]   out_bin_q, out_bin_d;
  logic            out_last_q, out_last_d;
  logic [RN-1:0]   peak_mag_q, peak_mag_d;
  logic [BW-1:0]   peak_bin_q, peak_bin_d;
  logic            pick;

  // Output decode from registered state; reset drops everything at once.
  always_comb begin
    gnt         = gnt_q;
    done        = (state_q == S_DONE) ? gnt_q : '0;
    err         = (state_q == S_DONE) && abort_q;
    fft_request = (state_q == S_RUN);
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    out_bin     = out_bin_q;
    out_last    = out_last_q;
    peak_mag    = peak_mag_q;
    peak_bin    = peak_bin_q;
  end

  // Next-state, arbitration, beat tagging and peak tracking.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    abort_d     = abort_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;
    out_bin_d   = out_bin_q;
    peak_mag_d  = peak_mag_q;
    peak_bin_d  = peak_bin_q;
    // Both pending: take the one not granted last; otherwise the sole one.
    pick        = (req == 2'b11) ? ~last_gnt_q : req[1];

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d    = S_RUN;
          gnt_d      = pick ? 2'b10 : 2'b01;
          last_gnt_d = pick;
          cnt_d      = '0;
          tmo_d      = '0;
          abort_d    = 1'b0;
          peak_mag_d = '0;
          peak_bin_d = '0;
        end
      end
      S_RUN: begin
        if (fft_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = fft_data;
          out_bin_d   = cnt_q;
          out_last_d  = (cnt_q == BW'(SIZE - 1));
          cnt_d       = cnt_q + 1'b1;
          tmo_d       = '0;
          if (fft_data > peak_mag_q) begin
            peak_mag_d = fft_data;
            peak_bin_d = cnt_q;
          end
          if (cnt_q == BW'(SIZE - 1)) begin
            state_d = S_DONE;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          abort_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        gnt_d   = '0;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      abort_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bin_q   <= '0;
      out_last_q  <= 1'b0;
      peak_mag_q  <= '0;
      peak_bin_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      abort_q     <= abort_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bin_q   <= out_bin_d;
      out_last_q  <= out_last_d;
      peak_mag_q  <= peak_mag_d;
      peak_bin_q  <= peak_bin_d;
    end
  end

endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: directed bench for fft_sched with SIZE=8, TIMEOUT=16, GAP=2.
module tb_fft_sched;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  gnt, done;
  logic        err, fft_request;
  logic        fft_valid = 1'b0;
  logic [15:0] fft_data = '0;
  logic        out_valid, out_last;
  logic [15:0] out_data, peak_mag;
  logic [2:0]  out_bin, peak_bin;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fft_sched #(.RN(16), .SIZE(8), .TIMEOUT(16), .GAP(2)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .gnt(gnt), .done(done),
    .err(err), .fft_request(fft_request), .fft_valid(fft_valid),
    .fft_data(fft_data), .out_valid(out_valid), .out_data(out_data),
    .out_bin(out_bin), .out_last(out_last), .peak_mag(peak_mag),
    .peak_bin(peak_bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    req = '0;
    fft_valid = 1'b0;
    fft_data = '0;
    tick();
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  // Drives n beats starting at bin 'first' and checks their tagging.
  task automatic beats(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      fft_valid = 1'b1;
      fft_data = 16'(10 + first + i);
      tick();
      chk("beat_valid", 32'(out_valid), 1);
      chk("beat_bin", 32'(out_bin), 32'(first + i));
      chk("beat_last", 32'(out_last), 32'((first + i) == 7));
    end
    fft_valid = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] exp);
    int n;
    n = 0;
    while (gnt == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait_bound", 32'(n < 20), 1);
    chk("grant", 32'(gnt), 32'(exp));
    chk("grant_request", 32'(fft_request), 1);
  endtask

  initial begin
    int unsigned d1 [8];
    int n, low;
    bit seen_last;
    d1 = '{3, 9, 2, 9, 0, 1, 7, 5};

    // Reset values.
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_req", 32'(fft_request), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_oval", 32'(out_valid), 0);
    chk("rst_peak", 32'(peak_mag), 0);
    do_reset();

    // Single requester full frame; tie on 9 keeps bin 1.
    req = 2'b01;
    tick();
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_fftreq", 32'(fft_request), 1);
    for (int i = 0; i < 8; i++) begin
      fft_valid = 1'b1;
      fft_data = 16'(d1[i]);
      tick();
      chk("t1_oval", 32'(out_valid), 1);
      chk("t1_odata", 32'(out_data), d1[i]);
      chk("t1_bin", 32'(out_bin), 32'(i));
      chk("t1_last", 32'(out_last), 32'(i == 7));
    end
    fft_valid = 1'b0;
    req = 2'b00;
    chk("t1_done", 32'(done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_done_gnt", 32'(gnt), 1);
    chk("t1_done_fftreq", 32'(fft_request), 0);
    chk("t1_peak_mag", 32'(peak_mag), 9);
    chk("t1_peak_bin", 32'(peak_bin), 1);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_gap_gnt", 32'(gnt), 0);

    // Stray fft_valid during Gap and Idle is ignored.
    for (int i = 0; i < 5; i++) begin
      fft_valid = 1'b1;
      fft_data = 16'hFFFF;
      tick();
      chk("t4_no_oval", 32'(out_valid), 0);
      chk("t4_peak_hold", 32'(peak_mag), 9);
    end
    fft_valid = 1'b0;
    req = 2'b01;
    tick();
    chk("t4_gnt", 32'(gnt), 1);
    chk("t4_peak_clear", 32'(peak_mag), 0);
    beats(0, 1);
    chk("t4_peak_first", 32'(peak_mag), 10);
    req = 2'b00;
    beats(1, 7);
    chk("t4_done", 32'(done), 1);

    // Both requesters pending: alternate 01, 10, 01.
    do_reset();
    req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      wait_grant((f == 1) ? 2'b10 : 2'b01);
      beats(0, 8);
      chk("t2_done", 32'(done), (f == 1) ? 2 : 1);
      if (f == 2) req = 2'b00;
      low = 0;
      while (fft_request == 1'b0 && low < 20) begin
        low++;
        tick();
      end
      // Done + GAP cycles + one Idle arbitration cycle.
      if (f < 2) chk("t2_low_cycles", 32'(low), 4);
    end

    // Timeout: 3 beats then silence.
    do_reset();
    req = 2'b01;
    tick();
    chk("t3_gnt", 32'(gnt), 1);
    for (int i = 0; i < 3; i++) begin
      fft_valid = 1'b1;
      fft_data = (i == 1) ? 16'd12 : 16'(5 + i);
      tick();
    end
    fft_valid = 1'b0;
    seen_last = 1'b0;
    n = 0;
    while (done == 2'b00 && n < 40) begin
      tick();
      n++;
      if (out_last) seen_last = 1'b1;
    end
    chk("t3_timeout_cycles", 32'(n), 16);
    chk("t3_done", 32'(done), 1);
    chk("t3_err", 32'(err), 1);
    chk("t3_no_last", 32'(seen_last), 0);
    chk("t3_peak_mag", 32'(peak_mag), 12);
    chk("t3_peak_bin", 32'(peak_bin), 1);
    req = 2'b00;
    tick();
    chk("t3_err_pulse", 32'(err), 0);

    // Asynchronous reset mid-frame.
    do_reset();
    req = 2'b11;
    tick();
    chk("t5_gnt", 32'(gnt), 1);
    beats(0, 4);
    fft_valid = 1'b1;
    n_reset = 1'b0;
    #1;
    chk("t5_rst_fftreq", 32'(fft_request), 0);
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_oval", 32'(out_valid), 0);
    chk("t5_rst_peak", 32'(peak_mag), 0);
    fft_valid = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();
    chk("t5_regrant", 32'(gnt), 1);
    req = 2'b00;
    beats(0, 8);
    chk("t5_done", 32'(done), 1);

    // Requester drops mid-frame: frame completes, no new grant.
    do_reset();
    req = 2'b01;
    tick();
    beats(0, 2);
    req = 2'b00;
    beats(2, 6);
    chk("t6_done", 32'(done), 1);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_gnt", 32'(gnt), 0);
    chk("t6_no_fftreq", 32'(fft_request), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
